// File: rtl/scl_out_retimer_if.sv
// Video stream bundle (syncs, pixel valid, RGB) shared by the scaler side and the
// re-timed output side of the re-timer.
interface scl_out_retimer_if #(
    parameter int DW = 8
);
    logic          vsync;
    logic          hsync;
    logic          data_en;
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;

    modport master (output vsync, hsync, data_en, r, g, b);
    modport slave  (input  vsync, hsync, data_en, r, g, b);
endinterface

// File: rtl/scl_out_retimer.sv
// Line re-timer behind the horizontal scaler: stores gapped pixels of a line in a FIFO and
// replays each closed line as a contiguous burst followed by a regenerated hsync pulse.
//
//   state    | meaning
//   ST_IDLE  | waiting for a closed (pending) line
//   ST_BURST | one FIFO read per cycle until the line length is exhausted
//   ST_HSYNC | regenerated hsync, HS_W cycles long
module scl_out_retimer #(
    parameter int DW   = 8,
    parameter int AW   = 10,
    parameter int HS_W = 8
) (
    input  logic              clk_scl,
    input  logic              rst_n_scl,
    input  logic              cfg_mode_i,
    scl_out_retimer_if.slave  vid_i,
    scl_out_retimer_if.master vid_o,
    output logic [AW:0]       out_line_len_o,
    output logic              err_flag_o
);
    localparam int PW = 3 * DW;
    localparam int HW = $clog2(HS_W + 1);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [HW-1:0] HS_LOAD = HW'(HS_W);
    localparam logic [HW-1:0] HS_ONE  = HW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_HSYNC} state_t;

    state_t        state_q, state_d;
    logic          vs_q, vs2_q, hs_q, hs2_q;
    logic          vs_rise, hs_rise;

    logic [PW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [AW:0]   pend_len_q, pend_len_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [AW:0]   line_len_q, line_len_d;
    logic [HW-1:0] hs_cnt_q, hs_cnt_d;
    logic          pend_valid_q, pend_valid_d;
    logic          err_q, err_d;

    logic          fifo_full, fifo_empty;
    logic          push, drop, close;
    logic [AW:0]   close_len;
    logic          rd_en, start, underflow;

    logic          out_hs_q, out_hs_d;
    logic          out_en_q, out_en_d;
    logic [PW-1:0] out_pix_q, out_pix_d;
    logic [PW-1:0] in_pix;

    assign in_pix     = {vid_i.r, vid_i.g, vid_i.b};
    assign vs_rise    = vs_q & ~vs2_q;
    assign hs_rise    = hs_q & ~hs2_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pixel pushed in the same cycle as hs_rise still belongs to the closing line.
    assign push      = cfg_mode_i & vid_i.data_en & ~fifo_full & ~vs_rise;
    assign drop      = cfg_mode_i & vid_i.data_en &  fifo_full & ~vs_rise;
    assign close_len = wr_cnt_q + {{AW{1'b0}}, push};
    assign close     = cfg_mode_i & hs_rise & ~vs_rise & (close_len != '0);

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        hs_cnt_d  = hs_cnt_q;
        rd_en     = 1'b0;
        start     = 1'b0;
        underflow = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    state_d  = ST_BURST;
                    rd_cnt_d = pend_len_q;
                    start    = 1'b1;
                end
            end
            ST_BURST: begin
                if (fifo_empty) begin
                    state_d   = ST_HSYNC;
                    hs_cnt_d  = HS_LOAD;
                    underflow = 1'b1;
                end else begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q - PTR_ONE;
                    if (rd_cnt_q == PTR_ONE) begin
                        state_d  = ST_HSYNC;
                        hs_cnt_d = HS_LOAD;
                    end
                end
            end
            ST_HSYNC: begin
                hs_cnt_d = hs_cnt_q - HS_ONE;
                if (hs_cnt_q == HS_ONE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (vs_rise || !cfg_mode_i) begin
            state_d   = ST_IDLE;
            rd_en     = 1'b0;
            start     = 1'b0;
            underflow = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_cnt_d     = wr_cnt_q;
        pend_len_d   = pend_len_q;
        pend_valid_d = pend_valid_q;
        line_len_d   = line_len_q;
        err_d        = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            wr_cnt_d = wr_cnt_q + PTR_ONE;
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (start) begin
            pend_valid_d = 1'b0;
            line_len_d   = pend_len_q;
        end
        if (close) begin
            pend_len_d   = close_len;
            pend_valid_d = 1'b1;
            wr_cnt_d     = '0;
        end
        // A pending line is only really lost if it is not being picked up this cycle.
        if (drop || underflow || (close && pend_valid_q && !start)) err_d = 1'b1;
        if (vs_rise || !cfg_mode_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            wr_cnt_d     = '0;
            pend_valid_d = 1'b0;
        end
        if (vs_rise) err_d = 1'b0;
    end

    always_comb begin
        out_hs_d  = 1'b0;
        out_en_d  = 1'b0;
        out_pix_d = '0;
        if (!cfg_mode_i) begin
            out_hs_d  = vid_i.hsync;
            out_en_d  = vid_i.data_en;
            out_pix_d = in_pix;
        end else begin
            out_hs_d = (state_q == ST_HSYNC) && !vs_rise;
            out_en_d = rd_en;
            if (rd_en) out_pix_d = mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_scl) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= in_pix;
    end

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            state_q      <= ST_IDLE;
            vs_q         <= 1'b0;
            vs2_q        <= 1'b0;
            hs_q         <= 1'b0;
            hs2_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_cnt_q     <= '0;
            pend_len_q   <= '0;
            rd_cnt_q     <= '0;
            line_len_q   <= '0;
            hs_cnt_q     <= '0;
            pend_valid_q <= 1'b0;
            err_q        <= 1'b0;
            out_hs_q     <= 1'b0;
            out_en_q     <= 1'b0;
            out_pix_q    <= '0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vid_i.vsync;
            vs2_q        <= vs_q;
            hs_q         <= vid_i.hsync;
            hs2_q        <= hs_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_cnt_q     <= wr_cnt_d;
            pend_len_q   <= pend_len_d;
            rd_cnt_q     <= rd_cnt_d;
            line_len_q   <= line_len_d;
            hs_cnt_q     <= hs_cnt_d;
            pend_valid_q <= pend_valid_d;
            err_q        <= err_d;
            out_hs_q     <= out_hs_d;
            out_en_q     <= out_en_d;
            out_pix_q    <= out_pix_d;
        end
    end

    assign vid_o.vsync    = vs2_q;
    assign vid_o.hsync    = out_hs_q;
    assign vid_o.data_en  = out_en_q;
    assign vid_o.r        = out_pix_q[3*DW-1:2*DW];
    assign vid_o.g        = out_pix_q[2*DW-1:DW];
    assign vid_o.b        = out_pix_q[DW-1:0];
    assign out_line_len_o = line_len_q;
    assign err_flag_o     = err_q;
endmodule
